alu_result_sel_pipe: RTL and testbench
======================================

// Module: alu_result_sel_pipe
// PURPOSE
//  Parametrised successor of the 5-input ALU result selector: picks one ALU unit result per AluCtrl
//  code at WIDTH bits and registers it behind a valid/ready 2-entry skid buffer with Zero/Neg flags.
//  Sits between the ALU functional units and the writeback stage.
//  Lets the datapath stall without dropping or duplicating results.
// PARAMETERS
//  WIDTH  16  datapath width in bits (>=2)
// PORTS
//  Clock     in   1      rising-edge clock, single clock domain
//  Reset     in   1      synchronous, active-high reset
//  InValid   in   1      upstream offers a result set this cycle
//  InReady   out  1      block can accept this cycle (registered)
//  AluCtrl   in   3      result select code
//  oAND      in   WIDTH  AND unit result
//  oOR       in   WIDTH  OR unit result
//  oXOR      in   WIDTH  XOR unit result
//  oADDSUB   in   WIDTH  adder/subtractor result
//  oSLTI     in   1      set-less-than-immediate bit
//  Less      in   1      set-less-than bit
//  OutValid  out  1      Dalja/flags hold a valid result
//  OutReady  in   1      downstream consumes when OutValid&&OutReady
//  Dalja     out  WIDTH  selected result
//  Zero      out  1      Dalja == 0
//  Neg       out  1      Dalja[WIDTH-1]
// BEHAVIOUR
//  Select (combinational on inputs, sampled on accept):
//   000 oAND | 001 {0,oSLTI} | 010 oOR | 011 oXOR | 10x oADDSUB | 11x {0,Less}
//   1-bit sources zero-extended to WIDTH; no truncation or sign extension.
//  Storage: main reg M (drives outputs) + skid reg S, each with a valid bit Mv/Sv.
//  Flags are computed from the selected value on capture and stored with it, never recomputed from Dalja.
//  OutValid = Mv; InReady = !Sv (register output, no comb path from OutReady).
//  Accept = InValid && InReady; Pop = Mv && OutReady.
//  Per-edge update, priority top-down:
//   Reset: Mv=0, Sv=0, Dalja=0, Zero=0, Neg=0, InReady=1 on the following cycle.
//   Pop && Sv: M<=S, Sv<=0 (Accept is impossible since InReady=0).
//   Accept && (!Mv || Pop): M<=new, Mv<=1.
//   Accept && Mv && !Pop: S<=new, Sv<=1.
//   Pop && !Accept && !Sv: Mv<=0.
//   Otherwise hold all state.
//  Latency: accept at edge N -> OutValid/Dalja valid after edge N (visible in cycle N+1).
//  Throughput: 1 result/cycle when OutReady held high.
//  Results leave in acceptance order, each exactly once.
//  InValid with InReady=0: no capture; upstream must hold its data.
//  Dalja/Zero/Neg stay stable while OutValid && !OutReady.
//  Dalja/Zero/Neg keep their last values when Mv=0 (don't-care to the consumer).
//  Reset mid-operation: both entries discarded; no partial or late output after Reset deasserts.
//  Reset wins over a simultaneous Accept/Pop.
//  X on unused AluCtrl bits when InValid=0 must not corrupt state.
// TESTING
//  Hold Reset 2 cycles with InValid=1 -> OutValid=0, InReady=1, Dalja=0 and no capture.
//  WIDTH=16, OutReady=1; AluCtrl=000..111 with oAND=00F0, oOR=0F00, oXOR=F000, oADDSUB=1234,
//   oSLTI=1, Less=1 -> Dalja 00F0,0001,0F00,F000,1234,1234,0001,0001, each one cycle after its accept.
//  oADDSUB=0000 on AluCtrl=100 -> Zero=1, Neg=0; oADDSUB=8001 -> Zero=0, Neg=1.
//  Accept A,B,C back-to-back with OutReady=0 -> A held on Dalja, B in skid, InReady=0 from the 3rd cycle, C not taken;
//   raise OutReady -> A, B, C out in order, no loss or duplicate.
//  Continuous InValid with OutReady toggling 1010... over 20 results -> output sequence equals input sequence.
//  Two entries held, Reset pulsed 1 cycle -> OutValid=0 next cycle, no stale result appears afterwards.

Source files
------------

// File: rtl/alu_result_sel_pipe.sv
// Selects one ALU unit result by AluCtrl and hands it to writeback through a 2-entry skid buffer.
// Latency: a result accepted at edge N appears on Dalja/Zero/Neg after edge N (1 cycle).
// Backpressure: InReady is registered (!skid valid); OutReady has no combinational path to InReady.
module alu_result_sel_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       AluCtrl,
  input  logic [WIDTH-1:0] oAND,
  input  logic [WIDTH-1:0] oOR,
  input  logic [WIDTH-1:0] oXOR,
  input  logic [WIDTH-1:0] oADDSUB,
  input  logic             oSLTI,
  input  logic             Less,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Dalja,
  output logic             Zero,
  output logic             Neg
);

  // Main entry (drives the outputs) and skid entry, each with its own flags.
  logic [WIDTH-1:0] m_dat_q, m_dat_d;
  logic             m_zero_q, m_zero_d;
  logic             m_neg_q, m_neg_d;
  logic             m_vld_q, m_vld_d;
  logic [WIDTH-1:0] s_dat_q, s_dat_d;
  logic             s_zero_q, s_zero_d;
  logic             s_neg_q, s_neg_d;
  logic             s_vld_q, s_vld_d;
  logic             in_rdy_q, in_rdy_d;

  logic [WIDTH-1:0] sel_dat;
  logic             sel_zero;
  logic             sel_neg;
  logic             accept;
  logic             pop;

  // Result mux; 1-bit sources are zero-extended. Unknown codes fall to zero and are only
  // ever captured when InValid is high, so X on AluCtrl while idle cannot reach state.
  always_comb begin
    sel_dat = '0;
    case (AluCtrl)
      3'b000:         sel_dat = oAND;
      3'b001:         sel_dat = {{(WIDTH-1){1'b0}}, oSLTI};
      3'b010:         sel_dat = oOR;
      3'b011:         sel_dat = oXOR;
      3'b100, 3'b101: sel_dat = oADDSUB;
      3'b110, 3'b111: sel_dat = {{(WIDTH-1){1'b0}}, Less};
      default:        sel_dat = '0;
    endcase
    // Flags travel with the captured value rather than being derived from Dalja later.
    sel_zero = (sel_dat == '0);
    sel_neg  = sel_dat[WIDTH-1];
  end

  assign accept = InValid && in_rdy_q;
  assign pop    = m_vld_q && OutReady;

  // Skid-buffer next state: refill from skid first, then direct load, then park in skid, then drain.
  always_comb begin
    m_dat_d  = m_dat_q;
    m_zero_d = m_zero_q;
    m_neg_d  = m_neg_q;
    m_vld_d  = m_vld_q;
    s_dat_d  = s_dat_q;
    s_zero_d = s_zero_q;
    s_neg_d  = s_neg_q;
    s_vld_d  = s_vld_q;
    if (pop && s_vld_q) begin
      // InReady is low whenever the skid is full, so no accept can coincide here.
      m_dat_d  = s_dat_q;
      m_zero_d = s_zero_q;
      m_neg_d  = s_neg_q;
      s_vld_d  = 1'b0;
    end else if (accept && (!m_vld_q || pop)) begin
      m_dat_d  = sel_dat;
      m_zero_d = sel_zero;
      m_neg_d  = sel_neg;
      m_vld_d  = 1'b1;
    end else if (accept && m_vld_q && !pop) begin
      s_dat_d  = sel_dat;
      s_zero_d = sel_zero;
      s_neg_d  = sel_neg;
      s_vld_d  = 1'b1;
    end else if (pop && !accept && !s_vld_q) begin
      m_vld_d  = 1'b0;
    end
    in_rdy_d = !s_vld_d;
  end

  // State registers; reset discards both entries and overrides any same-cycle accept/pop.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      m_dat_q  <= '0;
      m_zero_q <= 1'b0;
      m_neg_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      s_dat_q  <= '0;
      s_zero_q <= 1'b0;
      s_neg_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      in_rdy_q <= 1'b1;
    end else begin
      m_dat_q  <= m_dat_d;
      m_zero_q <= m_zero_d;
      m_neg_q  <= m_neg_d;
      m_vld_q  <= m_vld_d;
      s_dat_q  <= s_dat_d;
      s_zero_q <= s_zero_d;
      s_neg_q  <= s_neg_d;
      s_vld_q  <= s_vld_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign InReady  = in_rdy_q;
  assign OutValid = m_vld_q;
  assign Dalja    = m_dat_q;
  assign Zero     = m_zero_q;
  assign Neg      = m_neg_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench for alu_result_sel_pipe at WIDTH=16.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next edge.
// A queue model of the 2-entry buffer predicts OutValid/InReady/Dalja/Zero/Neg every cycle.
module tb_alu_result_sel_pipe;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [2:0]  AluCtrl;
  logic [15:0] oAND, oOR, oXOR, oADDSUB;
  logic        oSLTI, Less;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Dalja;
  logic        Zero, Neg;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];    // model contents, head = value expected on Dalja
  logic [15:0] got[$];  // values observed leaving the DUT
  logic [15:0] sent[$];
  logic        acc;

  always #5 Clock = ~Clock;

  alu_result_sel_pipe #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .AluCtrl(AluCtrl), .oAND(oAND), .oOR(oOR), .oXOR(oXOR), .oADDSUB(oADDSUB),
    .oSLTI(oSLTI), .Less(Less), .OutValid(OutValid), .OutReady(OutReady),
    .Dalja(Dalja), .Zero(Zero), .Neg(Neg)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sel(input logic [2:0] c, input logic [15:0] a, o, x, s,
                                          input logic sl, ls);
    case (c)
      3'd0:    return a;
      3'd1:    return {15'd0, sl};
      3'd2:    return o;
      3'd3:    return x;
      3'd4:    return s;
      3'd5:    return s;
      default: return {15'd0, ls};
    endcase
  endfunction

  // One clock cycle: drive, predict, clock, check against the model.
  task automatic cyc(input string tag, input logic inv, input logic outr, input logic [2:0] ctrl,
                     input logic [15:0] d_and, d_or, d_xor, d_add, input logic sl, ls,
                     output logic took);
    logic pop;
    InValid = inv; OutReady = outr; AluCtrl = ctrl;
    oAND = d_and; oOR = d_or; oXOR = d_xor; oADDSUB = d_add; oSLTI = sl; Less = ls;
    took = inv && (q.size() < 2);
    pop  = (q.size() > 0) && outr;
    if (OutValid === 1'b1 && outr) got.push_back(Dalja);
    @(posedge Clock); #1;
    if (pop) void'(q.pop_front());
    if (took) q.push_back(exp_sel(ctrl, d_and, d_or, d_xor, d_add, sl, ls));
    chk1({tag, ".ovld"}, OutValid, q.size() != 0);
    chk1({tag, ".irdy"}, InReady, q.size() < 2);
    if (q.size() != 0) begin
      chk16({tag, ".dat"}, Dalja, q[0]);
      chk1({tag, ".zero"}, Zero, q[0] == 16'h0000);
      chk1({tag, ".neg"}, Neg, q[0][15]);
    end
  endtask

  // Simple add-unit transfer on code 100.
  task automatic add_cyc(input string tag, input logic inv, input logic outr, input logic [15:0] v,
                         output logic took);
    cyc(tag, inv, outr, 3'b100, 16'hAAAA, 16'h5555, 16'hFFFF, v, 1'b1, 1'b1, took);
  endtask

  task automatic do_reset(input string tag, input int n);
    Reset = 1'b1; InValid = 1'b1; OutReady = 1'b1; AluCtrl = 3'b011;
    oAND = 16'h1111; oOR = 16'h2222; oXOR = 16'h3333; oADDSUB = 16'h4444; oSLTI = 1'b1; Less = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      chk1({tag, ".ovld"}, OutValid, 1'b0);
      chk1({tag, ".irdy"}, InReady, 1'b1);
      chk16({tag, ".dat"}, Dalja, 16'h0000);
    end
    Reset = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [15:0] hand [8];
    int idx;
    hand = '{16'h00F0, 16'h0001, 16'h0F00, 16'hF000, 16'h1234, 16'h1234, 16'h0001, 16'h0001};

    // Reset held 2 cycles with InValid high: nothing captured.
    do_reset("rst", 2);
    add_cyc("post_rst", 1'b0, 1'b1, 16'h0000, acc);

    // Every select code, streaming with OutReady high.
    for (int c = 0; c < 8; c++) begin
      cyc("sel", 1'b1, 1'b1, 3'(c), 16'h00F0, 16'h0F00, 16'hF000, 16'h1234, 1'b1, 1'b1, acc);
      chk16("sel.hand", Dalja, hand[c]);
    end
    // Idle with X on AluCtrl: drains, must not capture.
    cyc("xidle", 1'b0, 1'b1, 3'bxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 1'bx, 1'bx, acc);
    cyc("xidle", 1'b0, 1'b1, 3'bxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 1'bx, 1'bx, acc);

    // Flags.
    add_cyc("flag0", 1'b1, 1'b1, 16'h0000, acc);
    chk1("flag0.zero", Zero, 1'b1);
    chk1("flag0.neg", Neg, 1'b0);
    add_cyc("flagn", 1'b1, 1'b1, 16'h8001, acc);
    chk1("flagn.zero", Zero, 1'b0);
    chk1("flagn.neg", Neg, 1'b1);
    cyc("slti0", 1'b1, 1'b1, 3'b001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, acc);
    chk16("slti0.dat", Dalja, 16'h0000);
    chk1("slti0.zero", Zero, 1'b1);
    add_cyc("drain", 1'b0, 1'b1, 16'h0000, acc);

    // Backpressure: A, B, C offered with OutReady low.
    got.delete();
    add_cyc("bp.a", 1'b1, 1'b0, 16'h1111, acc);
    add_cyc("bp.b", 1'b1, 1'b0, 16'h2222, acc);
    add_cyc("bp.c", 1'b1, 1'b0, 16'h3333, acc);
    chk1("bp.c_taken", acc, 1'b0);
    chk1("bp.irdy", InReady, 1'b0);
    chk16("bp.hold", Dalja, 16'h1111);
    add_cyc("bp.c2", 1'b1, 1'b0, 16'h3333, acc);
    chk16("bp.hold2", Dalja, 16'h1111);
    add_cyc("bp.r1", 1'b1, 1'b1, 16'h3333, acc);
    chk16("bp.r1.dat", Dalja, 16'h2222);
    add_cyc("bp.r2", 1'b1, 1'b1, 16'h3333, acc);
    chk16("bp.r2.dat", Dalja, 16'h3333);
    add_cyc("bp.r3", 1'b0, 1'b1, 16'h0000, acc);
    chk16("bp.n", 16'(got.size()), 16'd3);
    chk16("bp.o0", got[0], 16'h1111);
    chk16("bp.o1", got[1], 16'h2222);
    chk16("bp.o2", got[2], 16'h3333);

    // Continuous InValid with OutReady toggling: 20 results in order, each once.
    got.delete();
    sent.delete();
    for (int i = 0; i < 20; i++) sent.push_back(16'(i * 16'h0C35));
    idx = 0;
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      if (idx < 20) add_cyc("tog", 1'b1, (c % 2) == 0, sent[idx], acc);
      else          add_cyc("tog", 1'b0, (c % 2) == 0, 16'h0000, acc);
      if (acc) idx++;
    end
    chk16("tog.n", 16'(got.size()), 16'd20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk16("tog.seq", got[i], sent[i]);

    // Reset with both entries held: everything discarded.
    add_cyc("mid.a", 1'b1, 1'b0, 16'h5A5A, acc);
    add_cyc("mid.b", 1'b1, 1'b0, 16'hA5A5, acc);
    chk1("mid.full", InReady, 1'b0);
    do_reset("mid.rst", 1);
    got.delete();
    for (int i = 0; i < 3; i++) add_cyc("mid.after", 1'b0, 1'b1, 16'h0000, acc);
    chk16("mid.stale", 16'(got.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
